vga_fade_stage: RTL
===================

Name: vga_fade_stage

Overview:
- Final pixel output stage between the colour compositor (background/menu/game mux) and the VGA DAC pins.
- Registers sync, blanking and RGB onto the VGA pins with a fixed 2-cycle pipeline.
- Applies a frame-synchronous brightness fade, so menu↔game scene swaps happen behind a full-black screen.
- Exposes a request/black/done handshake to the scene controller.

Parameters:
- STEP_FRAMES, 2, frame pulses per brightness step (≥1).
- HOLD_FRAMES, 4, frame pulses held at black after swap is acknowledged (≥0).
- LVL_BITS, 5, width of brightness level; full scale LVL_MAX = 2^(LVL_BITS-1) = 16.

Ports:
- i_clk_pix  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_hsync  in  1  horizontal sync from timing generator
- i_vsync  in  1  vertical sync from timing generator
- i_de  in  1  display enable (active area)
- i_frame  in  1  one-cycle pulse at start of frame blanking
- i_red, i_green, i_blue  in  8 each  composited pixel colour
- i_fade_req  in  1  one-cycle pulse: start fade-out
- i_swap_done  in  1  one-cycle pulse: scene switched, fade back in
- o_fade_busy  out  1  high in any state except IDLE
- o_black  out  1  high only in BLACK state
- vga_hsync, vga_vsync  out  1 each  registered syncs
- vga_blank_n  out  1  registered display enable
- vga_sync_n  out  1  constant 1 after reset
- vga_r, vga_g, vga_b  out  8 each  scaled colour

Behaviour:
- Reset (async, i_rst_n=0):
  - All VGA outputs 0, including vga_sync_n.
  - FSM = IDLE, level = LVL_MAX, frame counter = 0.
  - o_fade_busy = 0, o_black = 0.
  - Reset mid-fade returns immediately to IDLE at full brightness.
- Pipeline: 2-cycle latency, identical for hsync, vsync, de and RGB, so alignment is preserved.
  - Stage 1 registers inputs and products c×level (13 bits).
  - Stage 2 registers (product >> (LVL_BITS-1)) truncated to 8 bits; the result never exceeds 255.
  - RGB output is 0 whenever the delayed de = 0.
  - vga_blank_n equals de delayed by 2 cycles.
- Level scaling: out = floor(c×L/16). L=16 passes colour unchanged; L=0 gives 0.
- Level update timing:
  - Level changes only on cycles with i_frame=1 (never mid-frame).
  - The new level is used by stage 1 from the following cycle.
- FSM, with frame counter fc counting i_frame pulses:
  - IDLE: i_fade_req=1 → FADE_OUT, fc=0.
  - FADE_OUT: on each i_frame, if fc==STEP_FRAMES-1 then fc=0 and level−=1, else fc+=1. When level becomes 0 → BLACK, fc=0.
  - BLACK: waits for i_swap_done (latched sticky while in BLACK). After the latch, count HOLD_FRAMES i_frame pulses, then → FADE_IN, fc=0. With HOLD_FRAMES=0, go → FADE_IN on the cycle after i_swap_done.
  - FADE_IN: same step rule as FADE_OUT with level+=1. When level reaches LVL_MAX → IDLE.
- Fade-out length: LVL_MAX×STEP_FRAMES frame pulses after the request (32 at defaults). Fade-in length is the same.
- i_fade_req outside IDLE is ignored; no queuing.
- i_swap_done outside BLACK is ignored.
- Simultaneous i_fade_req and i_frame in IDLE: the FSM enters FADE_OUT; that frame pulse is not counted.
- Simultaneous i_swap_done and i_frame in BLACK: the swap is latched; that frame pulse is not counted toward HOLD_FRAMES.
- o_fade_busy and o_black are registered state decodes, valid the cycle after a state transition.

Test Plan:
- Reset and passthrough: release reset with i_de=1, RGB=0x6B/E9/F2 → after 2 cycles vga_r/g/b = 6B/E9/F2, vga_sync_n=1, vga_blank_n=1. Toggle hsync → vga_hsync follows 2 cycles later. de=0 → RGB 0.
- Half brightness: i_fade_req, then 16 frame pulses (STEP_FRAMES=2) → level 8. Input FF/80/01 → output 7F/40/00. Level is constant between frame pulses.
- Full fade handshake: i_fade_req → o_fade_busy=1. After 32 frame pulses → o_black=1 and output 0 for input FFFFFF. Pulse i_swap_done, then 4 frame pulses → FADE_IN. After 32 more pulses → o_fade_busy=0, output equals input.
- Ignored events:
  - i_fade_req during FADE_OUT: no change to timing.
  - i_swap_done during FADE_OUT: not latched; BLACK still waits for a new pulse.
  - No i_swap_done for 100 frames: stays BLACK.
- Async reset mid-FADE_IN at level 9: all outputs 0 immediately. After release: IDLE, level 16, passthrough after 2 cycles.
- Coincident events: i_fade_req same cycle as i_frame → first level drop occurs on the 2nd subsequent frame pulse. i_swap_done with i_frame in BLACK → FADE_IN after exactly 4 further pulses.

Source files
------------

// File: rtl/vga_fade_stage_if.sv
// Signal bundle between the compositor/scene controller and the VGA output stage.
// Field names match the stage's pin names so board-level wiring stays readable.
interface vga_fade_stage_if;
  logic       i_hsync;
  logic       i_vsync;
  logic       i_de;
  logic       i_frame;
  logic [7:0] i_red;
  logic [7:0] i_green;
  logic [7:0] i_blue;
  logic       i_fade_req;
  logic       i_swap_done;
  logic       o_fade_busy;
  logic       o_black;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (
    output i_hsync, i_vsync, i_de, i_frame, i_red, i_green, i_blue,
           i_fade_req, i_swap_done,
    input  o_fade_busy, o_black, vga_hsync, vga_vsync, vga_blank_n,
           vga_sync_n, vga_r, vga_g, vga_b
  );

  modport slave (
    input  i_hsync, i_vsync, i_de, i_frame, i_red, i_green, i_blue,
           i_fade_req, i_swap_done,
    output o_fade_busy, o_black, vga_hsync, vga_vsync, vga_blank_n,
           vga_sync_n, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_fade_stage.sv
// Final VGA pixel stage: 2-cycle registered sync/blank/RGB path with a
// frame-synchronous brightness fade used to hide scene swaps behind black.
module vga_fade_stage #(
  parameter int STEP_FRAMES = 2,
  parameter int HOLD_FRAMES = 4,
  parameter int LVL_BITS    = 5
) (
  input logic              i_clk_pix,
  input logic              i_rst_n,
  vga_fade_stage_if.slave  bus
);

  localparam int LVL_MAX = 1 << (LVL_BITS - 1);
  localparam int PW      = 8 + LVL_BITS;
  localparam int FC_MAX  = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
  localparam int FC_W    = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FADE_OUT,
    ST_BLACK,
    ST_FADE_IN
  } state_e;

  state_e              state_q, state_d;
  logic [LVL_BITS-1:0] level_q, level_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic                swap_q, swap_d;
  logic                busy_q, busy_d;
  logic                black_q, black_d;

  logic                hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [PW-1:0]       pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic                hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  logic [7:0]          r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic                sync_n_q;

  logic                step_hit;
  assign step_hit = (fc_q == FC_W'(STEP_FRAMES - 1));

  // NOTE: every always_comb target gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fc_d    = fc_q;
    swap_d  = swap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_fade_req) begin
          state_d = ST_FADE_OUT;
          fc_d    = '0;
        end
      end
      ST_FADE_OUT: begin
        if (bus.i_frame) begin
          if (step_hit) begin
            fc_d    = '0;
            level_d = level_q - LVL_BITS'(1);
            if (level_q == LVL_BITS'(1)) state_d = ST_BLACK;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      ST_BLACK: begin
        // The swap pulse itself never counts as a hold frame.
        if (!swap_q) begin
          if (bus.i_swap_done) swap_d = 1'b1;
        end else if (HOLD_FRAMES == 0) begin
          state_d = ST_FADE_IN;
          fc_d    = '0;
          swap_d  = 1'b0;
        end else if (bus.i_frame) begin
          if (fc_q == FC_W'(HOLD_FRAMES - 1)) begin
            state_d = ST_FADE_IN;
            fc_d    = '0;
            swap_d  = 1'b0;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      ST_FADE_IN: begin
        if (bus.i_frame) begin
          if (step_hit) begin
            fc_d    = '0;
            level_d = level_q + LVL_BITS'(1);
            if (level_q == LVL_BITS'(LVL_MAX - 1)) state_d = ST_IDLE;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    black_d = (state_d == ST_BLACK);
  end

  always_comb begin
    hs1_d = bus.i_hsync;
    vs1_d = bus.i_vsync;
    de1_d = bus.i_de;
    pr_d  = PW'(bus.i_red)   * PW'(level_q);
    pg_d  = PW'(bus.i_green) * PW'(level_q);
    pb_d  = PW'(bus.i_blue)  * PW'(level_q);
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
    // Blanked pixels are forced black so the DAC never sees colour in porches.
    r2_d  = de1_q ? 8'(pr_q >> (LVL_BITS - 1)) : 8'h00;
    g2_d  = de1_q ? 8'(pg_q >> (LVL_BITS - 1)) : 8'h00;
    b2_d  = de1_q ? 8'(pb_q >> (LVL_BITS - 1)) : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      level_q  <= LVL_BITS'(LVL_MAX);
      fc_q     <= '0;
      swap_q   <= 1'b0;
      busy_q   <= 1'b0;
      black_q  <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      de1_q    <= 1'b0;
      pr_q     <= '0;
      pg_q     <= '0;
      pb_q     <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      de2_q    <= 1'b0;
      r2_q     <= '0;
      g2_q     <= '0;
      b2_q     <= '0;
      sync_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      fc_q     <= fc_d;
      swap_q   <= swap_d;
      busy_q   <= busy_d;
      black_q  <= black_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      de1_q    <= de1_d;
      pr_q     <= pr_d;
      pg_q     <= pg_d;
      pb_q     <= pb_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      de2_q    <= de2_d;
      r2_q     <= r2_d;
      g2_q     <= g2_d;
      b2_q     <= b2_d;
      sync_n_q <= 1'b1;
    end
  end

  assign bus.o_fade_busy = busy_q;
  assign bus.o_black     = black_q;
  assign bus.vga_hsync   = hs2_q;
  assign bus.vga_vsync   = vs2_q;
  assign bus.vga_blank_n = de2_q;
  assign bus.vga_sync_n  = sync_n_q;
  assign bus.vga_r       = r2_q;
  assign bus.vga_g       = g2_q;
  assign bus.vga_b       = b2_q;

endmodule
